// File: rtl/osd_link_arbiter.sv
// osd_link_arbiter: message-atomic round-robin arbiter for the OSD byte link with strobe pacing and owner timeout
module osd_link_arbiter #(
   parameter int MIN_GAP = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_start,
   input  logic [1:0]  req_last,
   input  logic [15:0] req_data,
   output logic [1:0]  req_ready,
   output logic        osd_strobe,
   output logic        osd_start,
   output logic [7:0]  osd_data,
   output logic        owner,
   output logic        busy,
   output logic        err_drop
);
   typedef enum logic {IDLE, OWN} state_t;
   localparam logic [3:0]  GAP_RELOAD = 4'(MIN_GAP - 1);
   localparam logic [15:0] T_LIM = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   state_t      state;
   logic [3:0]  gap;
   logic [15:0] tcnt;
   logic [1:0]  cand, drop;
   logic        grant, gport, xfer, tout;
   always_comb begin
      cand = req_valid & req_start;
      drop = req_valid & ~req_start & ((state == OWN) ? {~owner, owner} : 2'b11);
      grant = (state == IDLE) && (cand != 2'b00);
      gport = (cand == 2'b11) ? ~owner : cand[1];
      xfer = (state == OWN) && req_valid[owner] && (gap == 4'd0);
      tout = (state == OWN) && !xfer && (TIMEOUT != 0) && (tcnt >= T_LIM);
      req_ready = reset_n ? (drop | ({owner, ~owner} & {2{xfer}})) : 2'b00;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner      <= 1'b1;
         gap        <= 4'd0;
         tcnt       <= 16'd0;
         osd_strobe <= 1'b0;
         osd_start  <= 1'b0;
         osd_data   <= 8'd0;
         err_drop   <= 1'b0;
      end else begin
         osd_strobe <= xfer;
         err_drop   <= (drop != 2'b00) || tout;
         gap        <= xfer ? GAP_RELOAD : ((gap != 4'd0) ? gap - 4'd1 : 4'd0);
         tcnt       <= (xfer || state == IDLE) ? 16'd0 : tcnt + 16'd1;
         if (xfer) begin
            osd_start <= req_start[owner];
            osd_data  <= owner ? req_data[15:8] : req_data[7:0];
         end
         if (grant) begin
            owner <= gport;
            state <= OWN;
         end else if ((xfer && req_last[owner]) || tout) begin
            state <= IDLE;
         end
      end
   end
   assign busy = (state == OWN);
endmodule

// File: tb/tb_osd_link_arbiter.sv
// tb_osd_link_arbiter: directed and randomized bench for osd_link_arbiter with a message-level scoreboard
module tb_osd_link_arbiter;
   typedef struct packed {logic s; logic l; logic [7:0] d;} byte_t;
   typedef struct packed {int c; logic s; logic [7:0] d;} ev_t;

   logic clk = 0, reset_n = 0;
   logic [1:0] valid = 0, start = 0, last = 0;
   logic [15:0] data = 0;
   logic [1:0] a_ready;
   logic a_strobe, a_start, a_owner, a_busy, a_err;
   logic [7:0] a_data;
   logic [1:0] b_valid = 0, b_start = 0, b_last = 0;
   logic [15:0] b_data = 0;
   logic [1:0] b_ready;
   logic b_strobe, b_start_o, b_owner, b_busy, b_err;
   logic [7:0] b_data_o;

   int checks = 0, failures = 0, cyc = 0;
   byte_t q[2][$];
   byte_t bq[2][$];
   ev_t exq[$];
   int err_q[$];
   int starts[$];
   int strobes[$];
   logic busy_log[$];
   int bs_c[$];
   logic [7:0] bs_d[$];
   logic bs_s[$];
   logic [1:0] en = 0;
   int mown = -1, tout_at = -1, last_strobe = -100, rdy1 = 0, t0 = 0, k = 0;
   int acc_cyc[2];

   osd_link_arbiter #(.MIN_GAP(2), .TIMEOUT(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .req_valid(valid), .req_start(start), .req_last(last),
      .req_data(data), .req_ready(a_ready), .osd_strobe(a_strobe), .osd_start(a_start),
      .osd_data(a_data), .owner(a_owner), .busy(a_busy), .err_drop(a_err));

   osd_link_arbiter #(.MIN_GAP(1), .TIMEOUT(16)) dut_b (
      .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_start(b_start), .req_last(b_last),
      .req_data(b_data), .req_ready(b_ready), .osd_strobe(b_strobe), .osd_start(b_start_o),
      .osd_data(b_data_o), .owner(b_owner), .busy(b_busy), .err_drop(b_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic byte_t mk(input logic s, input logic l, input logic [7:0] d);
      byte_t r;
      r.s = s;
      r.l = l;
      r.d = d;
      return r;
   endfunction

   task automatic push_msg(input int p, input int n);
      for (int i = 0; i < n; i++) q[p].push_back(mk(i == 0, i == n - 1, 8'($urandom)));
   endtask

   // One clock of dut_a traffic: drive queue heads, then score strobes, drops and handshakes
   task automatic step();
      logic ee;
      for (int i = 0; i < 2; i++) begin
         valid[i] = en[i] && (q[i].size() > 0);
         start[i] = valid[i] && q[i][0].s;
         last[i] = valid[i] && q[i][0].l;
         data[8*i +: 8] = valid[i] ? q[i][0].d : 8'h00;
      end
      @(negedge clk);
      if (cyc == tout_at) begin
         mown = -1;
         chk("timeout_busy_low", a_busy, 0);
      end
      if (cyc == tout_at - 1) chk("pre_timeout_busy", a_busy, 1);
      ee = (err_q.size() > 0) && (err_q[0] == cyc);
      if (a_err || ee) begin
         chk("err_drop", a_err, ee);
         if (ee) void'(err_q.pop_front());
      end
      if (a_strobe || (exq.size() > 0 && exq[0].c == cyc)) begin
         if (exq.size() == 0) chk("strobe_unexpected", a_strobe, 0);
         else begin
            chk("strobe_present", a_strobe, 1);
            chk("strobe_cycle", cyc, exq[0].c);
            chk("osd_start", a_start, exq[0].s);
            chk("osd_data", a_data, exq[0].d);
            void'(exq.pop_front());
         end
         if (a_strobe) begin
            chk("strobe_spacing", (cyc - last_strobe) >= 2, 1);
            strobes.push_back(cyc);
            busy_log.push_back(a_busy);
            last_strobe = cyc;
         end
      end
      if (a_ready[1]) rdy1++;
      for (int i = 0; i < 2; i++) if (valid[i] && a_ready[i]) begin
         byte_t hb;
         ev_t e;
         hb = q[i].pop_front();
         acc_cyc[i] = cyc;
         if (hb.s) begin
            chk("no_interleave", (mown == -1) || (mown == i), 1);
            starts.push_back(i);
         end
         if (hb.s || mown == i) begin
            e.c = cyc + 1;
            e.s = hb.s;
            e.d = hb.d;
            exq.push_back(e);
            mown = hb.l ? -1 : i;
         end else err_q.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((q[0].size() > 0 || q[1].size() > 0 || exq.size() > 0 || err_q.size() > 0 || a_busy) && n < max) begin
         step();
         n++;
      end
      chk("drain_done", n < max, 1);
   endtask

   initial begin
      // reset held with both ports offering start bytes
      valid = 2'b11;
      start = 2'b11;
      data = 16'h1234;
      b_valid = 2'b11;
      b_start = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", a_ready, 0);
      chk("rst_strobe", a_strobe, 0);
      chk("rst_start", a_start, 0);
      chk("rst_data", a_data, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_err", a_err, 0);
      chk("rst_owner", a_owner, 1);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_b_owner", b_owner, 1);
      @(posedge clk);
      #1;
      b_valid = 0;
      b_start = 0;
      reset_n = 1;

      // two contending messages per port: expect p0,p1,p0,p1
      for (int m = 0; m < 2; m++) for (int p = 0; p < 2; p++) push_msg(p, $urandom_range(1, 4));
      en = 2'b11;
      step();
      chk("first_grant_owner", a_owner, 0);
      chk("first_grant_busy", a_busy, 1);
      drain(200);
      chk("rr_count", starts.size(), 4);
      for (int i = 0; i < starts.size() && i < 4; i++) chk("rr_order", starts[i], i % 2);

      // paced 10-byte message from port 0
      strobes.delete();
      busy_log.delete();
      q[0].push_back(mk(1, 0, 8'h02));
      q[0].push_back(mk(0, 0, 8'h05));
      q[0].push_back(mk(0, 0, 8'hAA));
      q[0].push_back(mk(0, 0, 8'h55));
      for (int i = 0; i < 5; i++) q[0].push_back(mk(0, 0, 8'($urandom)));
      q[0].push_back(mk(0, 1, 8'($urandom)));
      en = 2'b01;
      t0 = cyc;
      drain(100);
      chk("t2_strobes", strobes.size(), 10);
      if (strobes.size() == 10) begin
         chk("t2_first_strobe", strobes[0], t0 + 2);
         for (int i = 1; i < 10; i++) chk("t2_spacing", strobes[i] - strobes[i-1], 2);
         chk("t2_busy_before_last", busy_log[8], 1);
         chk("t2_busy_after_last", busy_log[9], 0);
      end

      // stray non-start byte from port 1 while port 0 owns
      strobes.delete();
      rdy1 = 0;
      push_msg(0, 5);
      en = 2'b01;
      repeat (3) step();
      q[1].push_back(mk(0, 0, 8'hEE));
      en = 2'b11;
      drain(100);
      chk("t4_stray_ready_cycles", rdy1, 1);
      chk("t4_p0_strobes", strobes.size(), 5);

      // owner stalls mid-message; timeout hands the link to pending port 1
      strobes.delete();
      q[0].push_back(mk(1, 0, 8'h01));
      en = 2'b01;
      k = 0;
      while (q[0].size() > 0 && k < 10) begin
         step();
         k++;
      end
      chk("t5_accept", q[0].size(), 0);
      tout_at = acc_cyc[0] + 17;
      err_q.push_back(tout_at);
      q[1].push_back(mk(1, 0, 8'h01));
      q[1].push_back(mk(0, 1, 8'h01));
      en = 2'b11;
      drain(100);
      chk("t5_strobes", strobes.size(), 3);
      if (strobes.size() == 3) chk("t5_p1_first_strobe", strobes[1], tout_at + 2);
      tout_at = -1;

      // MIN_GAP=1 instance: single-byte p0 message then p1 back-to-back
      bq[0].push_back(mk(1, 1, 8'h3C));
      bq[1].push_back(mk(1, 0, 8'h77));
      bq[1].push_back(mk(0, 1, 8'h88));
      t0 = cyc;
      for (int n = 0; n < 10; n++) begin
         for (int i = 0; i < 2; i++) begin
            b_valid[i] = bq[i].size() > 0;
            b_start[i] = b_valid[i] && bq[i][0].s;
            b_last[i] = b_valid[i] && bq[i][0].l;
            b_data[8*i +: 8] = b_valid[i] ? bq[i][0].d : 8'h00;
         end
         @(negedge clk);
         if (b_strobe) begin
            bs_c.push_back(cyc);
            bs_d.push_back(b_data_o);
            bs_s.push_back(b_start_o);
         end
         for (int i = 0; i < 2; i++) if (b_valid[i] && b_ready[i]) void'(bq[i].pop_front());
         @(posedge clk);
         #1;
      end
      chk("t6_strobes", bs_c.size(), 3);
      if (bs_c.size() == 3) begin
         chk("t6_p0_cycle", bs_c[0], t0 + 2);
         chk("t6_p1_cycle", bs_c[1], t0 + 4);
         chk("t6_p1_b2b", bs_c[2], t0 + 5);
         chk("t6_d0", bs_d[0], 8'h3C);
         chk("t6_d1", bs_d[1], 8'h77);
         chk("t6_d2", bs_d[2], 8'h88);
         chk("t6_s0", bs_s[0], 1);
         chk("t6_s1", bs_s[1], 1);
         chk("t6_s2", bs_s[2], 0);
      end
      chk("t6_owner", b_owner, 1);
      chk("t6_busy", b_busy, 0);

      // randomized soak with intermittent valid on both ports
      for (int m = 0; m < 6; m++) begin
         push_msg(0, $urandom_range(1, 5));
         push_msg(1, $urandom_range(1, 5));
      end
      for (int n = 0; n < 400 && (q[0].size() > 0 || q[1].size() > 0); n++) begin
         en = 2'($urandom_range(1, 3));
         step();
      end
      en = 2'b11;
      drain(200);
      chk("soak_queues_empty", q[0].size() + q[1].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
